// File: rtl/crossing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : crossing_pkg
// Description : Shared state encodings and light-sequence codes for the
//               crossing request stage.
// Revision    : 1.0 - initial release
// ============================================================================
package crossing_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] PENDING = 2'd1;
    localparam logic [1:0] REQUEST = 2'd2;
    localparam logic [1:0] WALK    = 2'd3;

    // Pedestrian/cyclist green as reported by the controller.
    localparam logic [4:0] WALK_CODE = 5'b10100;

endpackage
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// Module      : button_debounce
// Description : Two-flop synchroniser, stability-count debouncer and
//               single-cycle rising-edge pulse for a raw push-button.
// Revision    : 1.0 - initial release
// ============================================================================
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic button_in,
    output logic clean,
    output logic press
);

    localparam logic [3:0] c_CNT_LAST = 4'(DEBOUNCE_CYCLES - 1);

    logic       r_s1;
    logic       r_s2;
    logic       r_clean;
    logic       r_clean_d;
    logic [3:0] r_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= button_in;
            r_s2 <= r_s1;
        end
    end

    // The clean level only follows s2 after it has differed for the full window.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_clean <= 1'b0;
            r_cnt   <= 4'd0;
        end else if (r_s2 == r_clean) begin
            r_cnt <= 4'd0;
        end else if (r_cnt == c_CNT_LAST) begin
            r_clean <= r_s2;
            r_cnt   <= 4'd0;
        end else begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_clean_d <= 1'b0;
        end else begin
            r_clean_d <= r_clean;
        end
    end

    assign clean = r_clean;
    assign press = r_clean & ~r_clean_d;

endmodule
`default_nettype wire

// File: rtl/crossing_request.sv
`default_nettype none
// ============================================================================
// Module      : crossing_request
// Description : Request stage for the crossing light controller: debounced
//               button, WAIT lamp, start request and road-green hold-off.
// Revision    : 1.0 - initial release
// ============================================================================
module crossing_request
    import crossing_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MIN_GAP_CYCLES  = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       button,
    input  logic [4:0] lightseq,
    output logic       start,
    output logic       wait_lamp,
    output logic [7:0] served
);

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic [7:0] r_gap_cnt;
    logic [7:0] r_served;
    logic       w_clean;
    logic       w_press;
    logic       w_walk_seen;
    logic       w_walk_exit;

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock     (clock),
        .reset     (reset),
        .button_in (button),
        .clean     (w_clean),
        .press     (w_press)
    );

    assign w_walk_seen = (lightseq == WALK_CODE);
    assign w_walk_exit = (r_state == WALK) && !w_walk_seen;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Presses outside IDLE are dropped: there is no request queue.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_press)           w_next_state = PENDING;
            PENDING: if (r_gap_cnt == 8'd0) w_next_state = REQUEST;
            REQUEST: if (w_walk_seen)       w_next_state = WALK;
            WALK:    if (!w_walk_seen)      w_next_state = IDLE;
            default:                        w_next_state = IDLE;
        endcase
    end

    always_comb begin
        start     = 1'b0;
        wait_lamp = 1'b0;
        case (r_state)
            PENDING: wait_lamp = 1'b1;
            REQUEST: begin
                start     = 1'b1;
                wait_lamp = 1'b1;
            end
            default: begin
                start     = 1'b0;
                wait_lamp = 1'b0;
            end
        endcase
    end

    // Road-green hold-off restarts each time a walk phase finishes.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_gap_cnt <= 8'd0;
        end else if (w_walk_exit) begin
            r_gap_cnt <= 8'(MIN_GAP_CYCLES);
        end else if (r_gap_cnt != 8'd0) begin
            r_gap_cnt <= r_gap_cnt - 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_served <= 8'd0;
        end else if (w_walk_exit) begin
            r_served <= r_served + 8'd1;
        end
    end

    assign served = r_served;

    logic w_unused;
    assign w_unused = w_clean;

endmodule
`default_nettype wire

// File: tb/tb_crossing_request.sv
`default_nettype none
// ============================================================================
// Module      : tb_crossing_request
// Description : Directed self-checking bench for crossing_request.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_crossing_request;

    logic       clock;
    logic       reset;
    logic       button;
    logic [4:0] lightseq;
    logic       start;
    logic       wait_lamp;
    logic [7:0] served;

    int errors = 0;
    int checks = 0;

    localparam logic [4:0] c_ROAD = 5'b01001;
    localparam logic [4:0] c_WALK = 5'b10100;

    crossing_request #(
        .DEBOUNCE_CYCLES (4),
        .MIN_GAP_CYCLES  (8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .button    (button),
        .lightseq  (lightseq),
        .start     (start),
        .wait_lamp (wait_lamp),
        .served    (served)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
    endtask

    // One full crossing from IDLE with no hold-off outstanding.
    task automatic do_crossing();
        button = 1'b1;
        step(8);
        button = 1'b0;
        lightseq = c_WALK;
        step(1);
        lightseq = c_ROAD;
        step(1);
        step(10);
    endtask

    task automatic test_reset();
        button = 1'b0;
        lightseq = c_ROAD;
        do_reset();
        checks++;
        if (start !== 1'b0 || wait_lamp !== 1'b0 || served !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: start=%b wait=%b served=%0d, need 0 0 0", start, wait_lamp, served);
        end
    endtask

    task automatic test_request();
        lightseq = c_ROAD;
        button = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            step(1);
            checks++;
            if (wait_lamp !== (e >= 7) || start !== (e >= 8)) begin
                errors++;
                $display("FAIL request_edge%0d: start=%b wait=%b, need %b %b", e, start, wait_lamp, e >= 8, e >= 7);
            end
        end
        button = 1'b0;
        step(8);
        checks++;
        if (start !== 1'b1) begin
            errors++;
            $display("FAIL request_hold: start=%b, need 1", start);
        end
    endtask

    task automatic test_walk();
        lightseq = c_WALK;
        step(1);
        checks++;
        if (start !== 1'b0 || wait_lamp !== 1'b0) begin
            errors++;
            $display("FAIL walk_enter: start=%b wait=%b, need 0 0", start, wait_lamp);
        end
        lightseq = c_ROAD;
        step(1);
        checks++;
        if (served !== 8'd1 || start !== 1'b0 || wait_lamp !== 1'b0) begin
            errors++;
            $display("FAIL walk_exit: served=%0d start=%b wait=%b, need 1 0 0", served, start, wait_lamp);
        end
        step(10);
    endtask

    task automatic test_gap();
        button = 1'b1;
        step(8);
        button = 1'b0;
        step(8);
        lightseq = c_WALK;
        step(1);
        button = 1'b1;
        step(4);
        lightseq = c_ROAD;
        step(1);
        checks++;
        if (served !== 8'd2 || wait_lamp !== 1'b0) begin
            errors++;
            $display("FAIL gap_exit: served=%0d wait=%b, need 2 0", served, wait_lamp);
        end
        for (int k = 1; k <= 9; k++) begin
            step(1);
            checks++;
            if (wait_lamp !== (k >= 2) || start !== (k >= 9)) begin
                errors++;
                $display("FAIL gap_exit_plus%0d: start=%b wait=%b, need %b %b", k, start, wait_lamp, k >= 9, k >= 2);
            end
        end
        button = 1'b0;
    endtask

    task automatic test_bounce();
        do_reset();
        step(10);
        for (int k = 0; k < 16; k++) begin
            button = (k < 6) ? ~k[0] : 1'b0;
            step(1);
            checks++;
            if (start !== 1'b0 || wait_lamp !== 1'b0) begin
                errors++;
                $display("FAIL bounce_cycle%0d: start=%b wait=%b, need 0 0", k, start, wait_lamp);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int c = 0; c < 5; c++) do_crossing();
        button = 1'b1;
        step(8);
        button = 1'b0;
        checks++;
        if (start !== 1'b1 || served !== 8'd5) begin
            errors++;
            $display("FAIL pre_reset: start=%b served=%0d, need 1 5", start, served);
        end
        do_reset();
        checks++;
        if (start !== 1'b0 || wait_lamp !== 1'b0 || served !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset: start=%b wait=%b served=%0d, need 0 0 0", start, wait_lamp, served);
        end
        for (int k = 0; k < 12; k++) begin
            step(1);
            checks++;
            if (start !== 1'b0 || wait_lamp !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_idle%0d: start=%b wait=%b, need 0 0", k, start, wait_lamp);
            end
        end
    endtask

    task automatic test_held_reset();
        button = 1'b1;
        step(3);
        do_reset();
        for (int e = 1; e <= 10; e++) begin
            step(1);
            checks++;
            if (wait_lamp !== (e >= 7) || start !== (e >= 8)) begin
                errors++;
                $display("FAIL held_reset_edge%0d: start=%b wait=%b, need %b %b", e, start, wait_lamp, e >= 8, e >= 7);
            end
        end
        button = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        step(10);
        for (int c = 1; c <= 256; c++) begin
            do_crossing();
            checks++;
            if (served !== 8'(c)) begin
                errors++;
                $display("FAIL wrap_crossing%0d: served=%0d, need %0d", c, served, c % 256);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        button = 1'b0;
        lightseq = c_ROAD;
        test_reset();
        test_request();
        test_walk();
        test_gap();
        test_bounce();
        test_reset_mid();
        test_held_reset();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/crossing_request.md
Name: crossing_request

Overview:
- Upstream request stage for the pedestrian/cyclist crossing light controller.
- Takes the raw, bouncy, asynchronous push-button and produces a clean `start` level for the controller.
- Drives the "WAIT" lamp and enforces a minimum road-green gap between successive crossings.
- Observes the controller's 5-bit light sequence to know when a request has been served.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable samples required before the clean button level changes; legal range 2..15.
- MIN_GAP_CYCLES, 8: road-green hold-off, in cycles, after a walk phase ends before a new `start` may assert; legal range 0..255.

Ports:
- clock, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-high reset.
- button, input, 1: raw asynchronous push-button, high = pressed.
- lightseq, input, 5: current light sequence from the controller.
- start, output, 1: request to the controller, level, state-decoded.
- wait_lamp, output, 1: pedestrian WAIT indicator.
- served, output, 8: count of completed crossings; wraps 255 -> 0.

Behaviour:
- Reset is synchronous, active-high, on clock; all registers load at the edge where reset=1.
- Reset values: sync flops 0, clean level 0, debounce count 0, state IDLE, gap_cnt 0, served 0; hence start=0, wait_lamp=0.
- Synchroniser: two flops on `button` (s1, s2).
- Debouncer:
  - When s2 != clean: cnt increments each edge.
  - When s2 == clean: cnt clears to 0.
  - When s2 != clean and cnt == DEBOUNCE_CYCLES-1: clean <= s2 and cnt <= 0.
- `press`: one-cycle pulse on the 0->1 transition of clean, via a registered clean_d.
- Latency: button first sampled high at edge 1 -> clean=1 after edge 2+DEBOUNCE_CYCLES -> PENDING after edge 3+D -> REQUEST after edge 4+D, provided gap_cnt==0 (edge 8 with defaults).
- WALK_CODE = 5'b10100 (pedestrian/cyclist green).
- FSM states and transitions:
  - IDLE: start=0, wait_lamp=0; press -> PENDING.
  - PENDING: start=0, wait_lamp=1; gap_cnt==0 -> REQUEST.
  - REQUEST: start=1, wait_lamp=1; lightseq==WALK_CODE -> WALK.
  - WALK: start=0, wait_lamp=0; lightseq!=WALK_CODE -> IDLE. On that transition: gap_cnt <= MIN_GAP_CYCLES and served <= served+1, modulo 256.
- gap_cnt: decrements by 1 each edge while nonzero, in every state; loads on WALK->IDLE; if MIN_GAP_CYCLES=0 a pending request proceeds immediately.
- Presses in PENDING, REQUEST or WALK are ignored: no queueing, no second request.
- Button held continuously produces one press only; a new press requires clean to return to 0 first.
- lightseq==WALK_CODE while in IDLE or PENDING has no effect.
- Reset mid-operation, any state: aborts to IDLE at that edge; start drops after that edge.
- Button held high across reset deassertion: recognised as a fresh press after the normal latency.

Decomposition:
- Package crossing_pkg: state encoding constants (IDLE=2'd0, PENDING=2'd1, REQUEST=2'd2, WALK=2'd3) and WALK_CODE.
- Sub-module button_debounce: synchroniser, debounce counter and rising-edge pulse; parameter DEBOUNCE_CYCLES; ports clock, reset, button_in, clean, press.
- Top level holds the FSM, gap counter and served counter.

Test Plan:
- Reset, lightseq=01001, button=1 for 12 cycles -> wait_lamp=1 after edge 7, start=1 after edge 8, start stays 1 while lightseq != 10100.
- Button toggles 1,0,1,0,1,0 on consecutive cycles then 0 -> clean never rises, start=0 and wait_lamp=0 throughout.
- In REQUEST drive lightseq=10100 -> after next edge start=0, wait_lamp=0 (WALK); then lightseq=01001 -> IDLE with served=1 and gap_cnt=8.
- Valid press arriving 2 cycles after WALK exit -> PENDING (wait_lamp=1); start must not rise until gap_cnt reaches 0, i.e. REQUEST one edge after gap_cnt==0.
- Assert reset for one edge while in REQUEST with served=5 -> start=0, wait_lamp=0, served=0 after that edge; no start without a new press.
- Run 256 complete crossings -> served reads 255 after the 255th, 0 after the 256th.
